keypad_scan_debounce: RTL and testbench
=======================================

KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of row inputs.
REQ-002 SHALL have parameter COLS, default 4, number of column outputs.
REQ-003 SHALL have parameter SCAN_DIV, default 300_000, clk cycles per column dwell; legal range >= ROWS+2.
REQ-004 SHALL have parameter DEBOUNCE, default 4, consecutive differing samples needed to change a key state; legal range >= 1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, >= 2.
REQ-006 SHALL have port clk, input, 1 bit, single clock; one clock, reset asynchronous active-low.
REQ-007 SHALL have port rst_l, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port row, input, ROWS bits, active-low key sense, externally pulled up.
REQ-009 SHALL have port col, output, COLS bits, open-drain drive: 0 on the active column, z on all others.
REQ-010 SHALL have port keys, output, ROWS*COLS bits, debounced level per key, index = r*COLS + c.
REQ-011 SHALL have port evt_valid, output, 1 bit, FIFO non-empty.
REQ-012 SHALL have port evt_ready, input, 1 bit, consumer accept.
REQ-013 SHALL have port evt_code, output, clog2(ROWS*COLS) bits, key index at FIFO head.
REQ-014 SHALL have port evt_press, output, 1 bit, head event type: 1 = press, 0 = release.
REQ-015 SHALL have port overflow, output, 1 bit, sticky event-drop flag.
REQ-016 SHALL have port ovf_clr, input, 1 bit, synchronous clear of overflow.

Function
REQ-017 SHALL run a free-running divider 0..SCAN_DIV-1 and assert an internal tick in the cycle where it equals SCAN_DIV-1, then wrap to 0.
REQ-018 SHALL hold column index cidx and drive col[cidx]=0, all other col bits z, at all times including reset.
REQ-019 On tick, SHALL latch ~row into a sample register tagged with cidx, and advance cidx (COLS-1 wraps to 0).
REQ-020 SHALL run an eval FSM IDLE -> EVAL(r=0..ROWS-1) -> IDLE: tick at cycle T enters EVAL; row r is evaluated in cycle T+1+r.
REQ-021 SHALL keep one per-key debounce counter, width clog2(DEBOUNCE+1).
REQ-022 When a sample equals keys[k], the counter SHALL clear to 0.
REQ-023 When a sample differs from keys[k] and the counter is < DEBOUNCE-1, the counter SHALL increment.
REQ-024 When a sample differs from keys[k] and the counter == DEBOUNCE-1, keys[k] SHALL toggle, the counter SHALL clear, and an event {k, new level} SHALL be pushed.
REQ-025 An event pushed at the end of cycle T+1+r SHALL make evt_valid high at T+2+r when the FIFO was empty.
REQ-026 Pop SHALL occur on evt_valid && evt_ready; evt_code and evt_press SHALL be stable while evt_valid && !evt_ready.
REQ-027 Push into a full FIFO with a same-cycle pop SHALL be accepted, with no overflow.
REQ-028 Push into a full FIFO without a pop SHALL drop the event and set overflow; keys SHALL still update.
REQ-029 ovf_clr SHALL clear overflow in the next cycle; if a drop occurs in the same cycle, set SHALL win.
REQ-030 Scanning and debounce SHALL never stall on FIFO state or evt_ready.
REQ-031 Worst-case press-to-keys latency SHALL be DEBOUNCE*COLS*SCAN_DIV + ROWS + 1 cycles.

Reset
REQ-032 rst_l low SHALL immediately set: divider 0, cidx 0 (col[0]=0, others z), FSM IDLE, keys 0, all debounce counters 0, FIFO empty, evt_valid 0, evt_code 0, evt_press 0, overflow 0.
REQ-033 Reset asserted mid-EVAL or mid-FIFO-transfer SHALL discard all in-flight samples and queued events; no event SHALL appear after release until a fresh DEBOUNCE-sample qualification completes.

Verification (ROWS=COLS=4, SCAN_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4)
REQ-034 Reset release -> col cycles 4'b1110,1101,1011,0111 (z shown as 1), 8 clk each, wrapping; keys=0; evt_valid=0.
REQ-035 Hold key r=1,c=2 (row[1] low while col[2] active) -> keys[6]=1 after 3rd sample of column 2; one event code 6, press=1; release -> one event code 6, press=0.
REQ-036 Glitch row[0] low for 2 consecutive column-0 samples, then high -> keys[0] stays 0, no event.
REQ-037 evt_ready=0, 5 distinct key presses -> FIFO holds first 4 in order, overflow=1, keys shows all 5; ovf_clr pulse -> overflow=0.
REQ-038 FIFO full with push and pop in the same cycle -> push accepted, overflow stays 0, occupancy stays 4.
REQ-039 rst_l pulsed low during EVAL with 2 events queued -> evt_valid=0 next cycle, keys=0, no stale events after release.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner with per-key debounce and a small press/release event FIFO.
// One column is pulled low per dwell period. At the end of each dwell the row lines
// are sampled, and then one row per cycle is evaluated against its key's debounced
// level. A key whose level changes pushes an event, and the consumer drains events
// with a valid/ready handshake.
module keypad_scan_debounce #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 300_000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int NKEYS     = ROWS * COLS,
  localparam int CODE_W    = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [ROWS-1:0]   row,
  output wire  [COLS-1:0]   col,
  output logic [NKEYS-1:0]  keys,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_press,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_EVAL} state_t;

  // ---------------------------------------------------------------- scan timing
  logic [DIV_W-1:0]  div_reg;
  logic              tick;
  logic [CIDX_W-1:0] cidx_reg;
  logic [ROWS-1:0]   samp_reg;
  logic [CIDX_W-1:0] samp_col_reg;

  assign tick = (div_reg == DIV_W'(SCAN_DIV - 1));

  // Free-running dwell divider; tick marks the last cycle of a column dwell.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  // On tick capture the active-high row image for the column being driven, then move on.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cidx_reg     <= '0;
      samp_reg     <= '0;
      samp_col_reg <= '0;
    end else if (tick) begin
      samp_reg     <= ~row;
      samp_col_reg <= cidx_reg;
      cidx_reg     <= (cidx_reg == CIDX_W'(COLS - 1)) ? '0 : cidx_reg + CIDX_W'(1);
    end
  end

  // Open-drain column drive: only the active column is pulled low.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign col[gi] = (cidx_reg == CIDX_W'(gi)) ? 1'b0 : 1'bz;
    end
  endgenerate

  // ---------------------------------------------------------------- eval FSM
  state_t            state_reg, state_next;
  logic [RIDX_W-1:0] ridx_reg, ridx_next;
  logic              eval_en;

  // FSM state and row pointer registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg <= ST_IDLE;
      ridx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ridx_reg  <= ridx_next;
    end
  end

  // Walk the rows of the latched sample, one per cycle, after each tick.
  always_comb begin
    state_next = state_reg;
    ridx_next  = ridx_reg;
    eval_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tick) begin
          state_next = ST_EVAL;
          ridx_next  = '0;
        end
      end
      ST_EVAL: begin
        eval_en = 1'b1;
        if (ridx_reg == RIDX_W'(ROWS - 1)) begin
          state_next = ST_IDLE;
          ridx_next  = '0;
        end else begin
          ridx_next = ridx_reg + RIDX_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- debounce
  logic [CODE_W-1:0] eval_key;
  logic              samp_bit;
  logic [NKEYS-1:0]  keys_vec;
  logic [CNT_W-1:0]  cnt_arr [NKEYS];
  logic              cur_key;
  logic [CNT_W-1:0]  cur_cnt;
  logic              differ;
  logic              push;
  logic              push_press;

  assign eval_key   = CODE_W'(ridx_reg) * CODE_W'(COLS) + CODE_W'(samp_col_reg);
  assign samp_bit   = samp_reg[ridx_reg];
  assign cur_key    = keys_vec[eval_key];
  assign cur_cnt    = cnt_arr[eval_key];
  assign differ     = (samp_bit != cur_key);
  assign push       = eval_en && differ && (cur_cnt == CNT_W'(DEBOUNCE - 1));
  assign push_press = ~cur_key;
  assign keys       = keys_vec;

  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic             hit;
      logic             key_reg;
      logic [CNT_W-1:0] cnt_reg;

      assign hit          = eval_en && (eval_key == CODE_W'(gi));
      assign keys_vec[gi] = key_reg;
      assign cnt_arr[gi]  = cnt_reg;

      // Count consecutive disagreeing samples; flip the level on the qualifying one.
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          key_reg <= 1'b0;
          cnt_reg <= '0;
        end else if (hit) begin
          if (!differ) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(DEBOUNCE - 1)) begin
            key_reg <= ~key_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- event FIFO
  logic [CODE_W-1:0] code_mem  [FIFO_DEPTH];
  logic              press_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]  occ_reg;
  logic              ovf_reg;
  logic              fifo_full, fifo_empty, pop, wr_en, drop;

  assign fifo_full  = (occ_reg == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (occ_reg == '0);
  assign pop        = !fifo_empty && evt_ready;
  // A same-cycle pop frees the slot the write lands in, so a full FIFO still accepts.
  assign wr_en      = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  assign evt_valid  = !fifo_empty;
  assign evt_code   = fifo_empty ? '0 : code_mem[rd_ptr_reg];
  assign evt_press  = !fifo_empty && press_mem[rd_ptr_reg];
  assign overflow   = ovf_reg;

  // Event storage; contents are only observed through the valid-gated head outputs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      code_mem[wr_ptr_reg]  <= eval_key;
      press_mem[wr_ptr_reg] <= push_press;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a physical key array drives the row lines for the
// currently scanned column; a time-based reference model predicts keys, overflow and
// the event stream, and a negedge monitor compares the DUT against the scoreboard.
module tb_keypad_scan_debounce;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, FIFO_DEPTH = 4;
  localparam int NKEYS = ROWS * COLS;
  localparam int SCAN  = SCAN_DIV * COLS;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [3:0]  row = 4'hF;
  wire  [3:0]  col;
  logic [15:0] keys;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [3:0]  evt_code;
  logic        evt_press;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  keypad_scan_debounce #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_l(rst_l), .row(row), .col(col), .keys(keys),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_press(evt_press), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int code; bit press; } ev_t;
  typedef struct { int due; int key; bit s; } pend_t;

  int n_checks = 0;
  int n_errors = 0;
  int ev_seen  = 0;

  bit [15:0] key_down = '0;
  int        m_cyc = 0;
  bit [15:0] m_keys = '0;
  int        m_cnt [NKEYS];
  int        m_occ = 0;
  bit        m_ovf = 1'b0;
  pend_t     pend [$];
  ev_t       sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sample at the end of each dwell, judge row r 1+r cycles later.
  int    occ0, c_m;
  bit    pop_m, ev_m, drop_m;
  ev_t   e_m;
  pend_t p_m;
  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    forever begin
      @(posedge clk or negedge rst_l);
      if (!rst_l) begin
        m_cyc = 0; m_keys = '0; m_occ = 0; m_ovf = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        pend.delete(); sb.delete();
      end else begin
        occ0 = m_occ;
        pop_m = (occ0 > 0) && evt_ready;
        ev_m = 1'b0; drop_m = 1'b0;
        while (pend.size() > 0 && pend[0].due == m_cyc) begin
          p_m = pend.pop_front();
          if (p_m.s == m_keys[p_m.key]) m_cnt[p_m.key] = 0;
          else if (m_cnt[p_m.key] < DEBOUNCE - 1) m_cnt[p_m.key]++;
          else begin
            m_keys[p_m.key] = ~m_keys[p_m.key];
            m_cnt[p_m.key] = 0;
            ev_m = 1'b1; e_m.code = p_m.key; e_m.press = m_keys[p_m.key];
          end
        end
        if (pop_m) m_occ--;
        if (ev_m) begin
          if (occ0 < FIFO_DEPTH || pop_m) begin sb.push_back(e_m); m_occ++; end
          else drop_m = 1'b1;
        end
        if (drop_m) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
          c_m = (m_cyc / SCAN_DIV) % COLS;
          for (int r = 0; r < ROWS; r++)
            pend.push_back('{m_cyc + 1 + r, r * COLS + c_m, key_down[r * COLS + c_m]});
        end
        m_cyc++;
      end
    end
  end

  // Physical keypad: a held key pulls its row low while its column is the scanned one.
  initial begin
    forever begin
      @(negedge clk);
      for (int r = 0; r < ROWS; r++)
        row[r] = ~key_down[r * COLS + (m_cyc / SCAN_DIV) % COLS];
    end
  end

  // Monitor: compare outputs each cycle, pop the scoreboard on each handshake.
  ev_t mon_e;
  int  mon_c;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_keys", 32'(keys), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_evt_code", 32'(evt_code), 0);
        check("rst_evt_press", 32'(evt_press), 0);
        check("rst_col0", 32'(col[0]), 0);
      end else begin
        mon_c = (m_cyc / SCAN_DIV) % COLS;
        check("col_active", 32'(col[mon_c]), 0);
        check("keys", 32'(keys), 32'(m_keys));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("evt_valid", 32'(evt_valid), 32'(sb.size() > 0));
        if (evt_valid && sb.size() > 0) begin
          check("evt_code", 32'(evt_code), sb[0].code);
          check("evt_press", 32'(evt_press), 32'(sb[0].press));
          if (evt_ready) begin
            mon_e = sb.pop_front();
            ev_seen++;
            $display("EVT code=%0d press=%0d t=%0t", evt_code, evt_press, $time);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align(input int phase);
    int g;
    g = 0;
    while ((m_cyc % SCAN) != phase && g < 4 * SCAN) begin
      step(1);
      g++;
    end
    if ((m_cyc % SCAN) != phase) begin
      n_checks++; n_errors++;
      $display("FAIL align: got phase %0d expected %0d", m_cyc % SCAN, phase);
    end
  endtask

  int base;
  int idx;
  initial begin
    rst_l = 1'b0;
    step(4);
    rst_l = 1'b1;

    // Idle scanning after reset.
    step(70);
    check("idle_keys", 32'(keys), 0);
    check("idle_events", ev_seen, 0);

    // Single key r=1,c=2 press then release.
    base = ev_seen;
    align(1);
    key_down[6] = 1'b1;
    step(4 * SCAN);
    check("key6_pressed", 32'(keys), 32'h0040);
    key_down[6] = 1'b0;
    step(4 * SCAN);
    check("key6_released", 32'(keys), 0);
    check("key6_events", ev_seen - base, 2);

    // Two-sample glitch on key 0 must not qualify.
    base = ev_seen;
    align(1);
    key_down[0] = 1'b1;
    step(2 * SCAN);
    key_down[0] = 1'b0;
    step(3 * SCAN);
    check("glitch_keys", 32'(keys), 0);
    check("glitch_events", ev_seen - base, 0);

    // Five presses with the consumer stalled: four kept, one dropped.
    evt_ready = 1'b0;
    base = ev_seen;
    align(1);
    key_down = 16'h4292;
    step(4 * SCAN);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_keys", 32'(keys), 32'h4292);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);
    evt_ready = 1'b1;
    step(20);
    check("ovf_drain", ev_seen - base, 4);
    key_down = '0;
    step(4 * SCAN);

    // Full FIFO with push and pop in the same cycle.
    base = ev_seen;
    align(1);
    evt_ready = 1'b0;
    key_down = 16'h1113;
    step(79);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("same_cycle_ovf", 32'(overflow), 0);
    check("same_cycle_valid", 32'(evt_valid), 1);
    check("same_cycle_popped", ev_seen - base, 1);
    evt_ready = 1'b1;
    step(20);
    check("same_cycle_total", ev_seen - base, 5);
    key_down = '0;
    step(4 * SCAN);

    // Reset during evaluation with two events queued.
    align(1);
    evt_ready = 1'b0;
    key_down = 16'h0044;
    step(89);
    check("pre_rst_valid", 32'(evt_valid), 1);
    rst_l = 1'b0;
    #1;
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_keys", 32'(keys), 0);
    step(2);
    rst_l = 1'b1;
    evt_ready = 1'b1;
    base = ev_seen;
    step(60);
    check("no_stale_events", ev_seen - base, 0);
    step(60);
    check("requalified", ev_seen - base, 2);
    key_down = '0;
    step(4 * SCAN);

    // Randomized keys, handshake and clear; busy consumer then a slow one.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 23) == 0) begin
        idx = int'($urandom_range(0, NKEYS - 1));
        key_down[idx] = ~key_down[idx];
      end
      evt_ready = ($urandom_range(0, 9) < 7);
      ovf_clr = ($urandom_range(0, 49) == 0);
      step(1);
    end
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        idx = int'($urandom_range(0, NKEYS - 1));
        key_down[idx] = ~key_down[idx];
      end
      evt_ready = ($urandom_range(0, 9) < 2);
      ovf_clr = ($urandom_range(0, 79) == 0);
      step(1);
    end

    key_down = '0;
    evt_ready = 1'b1;
    ovf_clr = 1'b0;
    step(300);
    check("final_scoreboard_empty", sb.size(), 0);
    check("final_keys", 32'(keys), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
